// File: rtl/gfp8_pkg.sv
// ---------------------------------------------------------------------------
// gfp8_pkg
// Shared constants for the GFP8 (group floating point, 8-bit mantissa)
// datapath: field widths, group geometry, result widths and the lane
// decomposition used by the group dot-product block.
// ---------------------------------------------------------------------------
package gfp8_pkg;

    localparam int GFP8_EXP_BIAS      = 15;
    localparam int GFP8_EXP_BITS      = 5;
    localparam int GFP8_MAN_BITS      = 8;
    localparam int GFP8_GROUP_SIZE    = 32;
    localparam int GFP8_GROUPS_PER_NV = 4;

    localparam int RESULT_MAN_W = 32;
    localparam int RESULT_EXP_W = 8;

    // One multiplier lane handles 8 element pairs.
    localparam int LANE_ELEMS = 8;
    localparam int LANES      = GFP8_GROUP_SIZE / LANE_ELEMS;
    localparam int PRODUCT_W  = 2 * GFP8_MAN_BITS;
    // 8 products of magnitude <= 16384 reach +131072, which needs 19 bits signed.
    localparam int LANE_SUM_W = 19;
    // 32 products reach +524288 (2^19), which needs 21 bits signed.
    localparam int ACC_W      = 21;

    // Removes the bias from a 5-bit exponent field, producing a signed value
    // in -15..+16 at the result exponent width.
    function automatic logic signed [RESULT_EXP_W-1:0] unbias_exp(
        input logic [GFP8_EXP_BITS-1:0] exp_field
    );
        logic signed [RESULT_EXP_W-1:0] widened;
        widened = $signed({{(RESULT_EXP_W-GFP8_EXP_BITS){1'b0}}, exp_field});
        return widened - RESULT_EXP_W'(GFP8_EXP_BIAS);
    endfunction

endpackage

// File: rtl/gfp8_dot8_lane.sv
// ---------------------------------------------------------------------------
// gfp8_dot8_lane
// Combinational 8-element signed int8 x int8 dot product, shaped to map onto
// a single MLP72 hard multiplier block.
//
// Ports:
//   man_left    in   64   8 signed int8 mantissas, element k at [8k+7:8k]
//   man_right   in   64   8 signed int8 mantissas, same packing
//   partial_sum out  19   signed sum of the 8 element products
// ---------------------------------------------------------------------------
module gfp8_dot8_lane
    import gfp8_pkg::*;
(
    input  logic        [LANE_ELEMS*GFP8_MAN_BITS-1:0] man_left,
    input  logic        [LANE_ELEMS*GFP8_MAN_BITS-1:0] man_right,
    output logic signed [LANE_SUM_W-1:0]               partial_sum
);

    logic signed [PRODUCT_W-1:0] product [LANE_ELEMS];

    generate
        for (genvar gi = 0; gi < LANE_ELEMS; gi++) begin : g_product
            assign product[gi] = $signed(man_left[gi*GFP8_MAN_BITS +: GFP8_MAN_BITS])
                               * $signed(man_right[gi*GFP8_MAN_BITS +: GFP8_MAN_BITS]);
        end
    endgenerate

    // Products are sign-extended before summing so the 19-bit result is exact.
    always_comb begin
        partial_sum = '0;
        for (int i = 0; i < LANE_ELEMS; i++) begin
            partial_sum = partial_sum + LANE_SUM_W'(product[i]);
        end
    end

endmodule

// File: rtl/gfp8_group_dot_mlp.sv
// ---------------------------------------------------------------------------
// gfp8_group_dot_mlp
// Dot product of one 32-element GFP8 group pair. Four 8-element lanes feed a
// 4-way adder; the sum and the combined unbiased exponent are registered,
// giving a free-running pipeline with a latency of exactly one cycle.
//
// Parameters:
//   GROUP_ID  group index (0..3) inside the native vector; tag only
//
// Ports:
//   i_clk              in   1    clock
//   i_reset_n          in   1    asynchronous active-low reset
//   i_exp_left         in   8    [4:0] biased exponent, [7:5] ignored
//   i_man_left         in   256  32 signed int8 mantissas
//   i_exp_right        in   8    same encoding as i_exp_left
//   i_man_right        in   256  same packing as i_man_left
//   o_result_mantissa  out  32   signed sum of the 32 element products
//   o_result_exponent  out  8    signed unbiased exponent (-30..+32)
// ---------------------------------------------------------------------------
module gfp8_group_dot_mlp
    import gfp8_pkg::*;
#(
    parameter int GROUP_ID = 0
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset_n,
    input  logic        [7:0]                        i_exp_left,
    input  logic        [GFP8_GROUP_SIZE*GFP8_MAN_BITS-1:0] i_man_left,
    input  logic        [7:0]                        i_exp_right,
    input  logic        [GFP8_GROUP_SIZE*GFP8_MAN_BITS-1:0] i_man_right,
    output logic signed [RESULT_MAN_W-1:0]           o_result_mantissa,
    output logic signed [RESULT_EXP_W-1:0]           o_result_exponent
);

    localparam int LANE_BITS = LANE_ELEMS * GFP8_MAN_BITS;

    logic signed [LANE_SUM_W-1:0]   lane_sum [LANES];
    logic signed [ACC_W-1:0]        acc_next;
    logic signed [RESULT_MAN_W-1:0] mantissa_next;
    logic signed [RESULT_EXP_W-1:0] exponent_next;
    logic signed [RESULT_MAN_W-1:0] mantissa_reg;
    logic signed [RESULT_EXP_W-1:0] exponent_reg;

    // The upper three exponent bits carry no meaning for this block.
    logic unused_exp_bits;
    assign unused_exp_bits = &{1'b0, i_exp_left[7:GFP8_EXP_BITS], i_exp_right[7:GFP8_EXP_BITS]};

    // GROUP_ID is only a tag; reject out-of-range values at elaboration.
    generate
        if (GROUP_ID < 0 || GROUP_ID >= GFP8_GROUPS_PER_NV) begin : g_bad_group_id
            $error("gfp8_group_dot_mlp: GROUP_ID out of range");
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            gfp8_dot8_lane u_lane (
                .man_left    (i_man_left[gi*LANE_BITS +: LANE_BITS]),
                .man_right   (i_man_right[gi*LANE_BITS +: LANE_BITS]),
                .partial_sum (lane_sum[gi])
            );
        end
    endgenerate

    // 4-way combine of the lane partial sums; 21 bits cannot overflow.
    always_comb begin
        acc_next = '0;
        for (int i = 0; i < LANES; i++) begin
            acc_next = acc_next + ACC_W'(lane_sum[i]);
        end
        mantissa_next = RESULT_MAN_W'(acc_next);
        exponent_next = unbias_exp(i_exp_left[GFP8_EXP_BITS-1:0])
                      + unbias_exp(i_exp_right[GFP8_EXP_BITS-1:0]);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mantissa_reg <= '0;
            exponent_reg <= '0;
        end else begin
            mantissa_reg <= mantissa_next;
            exponent_reg <= exponent_next;
        end
    end

    assign o_result_mantissa = mantissa_reg;
    assign o_result_exponent = exponent_reg;

endmodule

// File: tb/tb_gfp8_group_dot_mlp.sv
// ---------------------------------------------------------------------------
// tb_gfp8_group_dot_mlp
// Directed-vector bench for gfp8_group_dot_mlp. Inputs change 1 time unit
// after a rising edge; outputs are sampled 1 time unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_gfp8_group_dot_mlp;

    logic               clk;
    logic               reset_n;
    logic [7:0]         exp_left;
    logic [255:0]       man_left;
    logic [7:0]         exp_right;
    logic [255:0]       man_right;
    logic signed [31:0] result_mantissa;
    logic signed [7:0]  result_exponent;

    int n_checks;
    int n_failures;

    gfp8_group_dot_mlp #(.GROUP_ID(2)) dut (
        .i_clk             (clk),
        .i_reset_n         (reset_n),
        .i_exp_left        (exp_left),
        .i_man_left        (man_left),
        .i_exp_right       (exp_right),
        .i_man_right       (man_right),
        .o_result_mantissa (result_mantissa),
        .o_result_exponent (result_exponent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] fill(input logic [7:0] b);
        logic [255:0] v;
        for (int k = 0; k < 32; k++) v[8*k +: 8] = b;
        return v;
    endfunction

    function automatic logic [255:0] ramp();
        logic [255:0] v;
        for (int k = 0; k < 32; k++) v[8*k +: 8] = 8'(k);
        return v;
    endfunction

    task automatic drive(input logic [7:0] el, input logic [255:0] ml,
                         input logic [7:0] er, input logic [255:0] mr);
        exp_left  = el;
        man_left  = ml;
        exp_right = er;
        man_right = mr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic signed [31:0] exp_man,
                             input logic signed [7:0] exp_exp);
        n_checks++;
        if (result_mantissa !== exp_man || result_exponent !== exp_exp) begin
            n_failures++;
            $display("FAIL %s: got man=%0d exp=%0d, expected man=%0d exp=%0d",
                     name, result_mantissa, result_exponent, exp_man, exp_exp);
        end else begin
            $display("ok   %s: man=%0d exp=%0d", name, result_mantissa, result_exponent);
        end
    endtask

    task automatic test_reset();
        drive(8'd15, fill(8'h01), 8'd15, fill(8'h01));
        reset_n = 1'b0;
        #2;
        check_out("reset_async_before_clock", 32'sd0, 8'sd0);
        step();
        check_out("reset_held_through_edge", 32'sd0, 8'sd0);
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_ones();
        drive(8'd15, fill(8'h01), 8'd15, fill(8'h01));
        step();
        check_out("ones_exp15_15", 32'sd32, 8'sd0);
        // Input change between edges must not reach the outputs.
        drive(8'd3, fill(8'h7F), 8'd9, fill(8'h7F));
        #3;
        check_out("ones_held_between_edges", 32'sd32, 8'sd0);
    endtask

    task automatic test_max_pos();
        drive(8'd20, fill(8'h80), 8'd10, fill(8'h80));
        step();
        check_out("max_pos_0x80sq", 32'sd524288, 8'sd0);
    endtask

    task automatic test_max_neg();
        drive(8'd31, fill(8'h7F), 8'd31, fill(8'h80));
        step();
        check_out("max_neg_7Fx80", -32'sd520192, 8'sd32);
    endtask

    task automatic test_ramp();
        drive(8'hE0, ramp(), 8'h00, fill(8'h01));
        step();
        check_out("ramp_upper_exp_bits", 32'sd496, -8'sd30);
    endtask

    task automatic test_mixed_sign();
        // -1 * 5 over 32 elements; exps (16-15)+(17-15)=3
        drive(8'd16, fill(8'hFF), 8'd17, fill(8'h05));
        step();
        check_out("neg_one_times_five", -32'sd160, 8'sd3);
    endtask

    task automatic test_back_to_back();
        // Each cycle: sample the previous vector's result, then present the next.
        drive(8'd15, fill(8'h01), 8'd15, fill(8'h01));
        step();
        drive(8'd20, fill(8'h80), 8'd10, fill(8'h80));
        check_out("b2b_0_ones", 32'sd32, 8'sd0);
        step();
        drive(8'd31, fill(8'h7F), 8'd31, fill(8'h80));
        check_out("b2b_1_max_pos", 32'sd524288, 8'sd0);
        step();
        drive(8'hE0, ramp(), 8'h00, fill(8'h01));
        check_out("b2b_2_max_neg", -32'sd520192, 8'sd32);
        step();
        drive(8'd15, fill(8'h01), 8'd15, fill(8'h01));
        check_out("b2b_3_ramp", 32'sd496, -8'sd30);
        step();
        check_out("b2b_4_ones", 32'sd32, 8'sd0);
    endtask

    task automatic test_reset_midstream();
        drive(8'd31, fill(8'h7F), 8'd31, fill(8'h80));
        step();
        check_out("mid_pre_reset_nonzero", -32'sd520192, 8'sd32);
        #2;
        reset_n = 1'b0;
        #1;
        check_out("mid_reset_immediate", 32'sd0, 8'sd0);
        step();
        check_out("mid_reset_held", 32'sd0, 8'sd0);
        #3;
        drive(8'd15, fill(8'h01), 8'd15, fill(8'h01));
        reset_n = 1'b1;
        #2;
        check_out("mid_released_before_edge", 32'sd0, 8'sd0);
        step();
        check_out("mid_first_after_release", 32'sd32, 8'sd0);
    endtask

    initial begin
        n_checks   = 0;
        n_failures = 0;
        reset_n    = 1'b1;
        drive(8'd0, '0, 8'd0, '0);
        #1;
        test_reset();
        test_ones();
        test_max_pos();
        test_max_neg();
        test_ramp();
        test_mixed_sign();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
